// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the accumulator CPU control sequencer.
// Bus selects, load-bit indices, opcodes, register-reference bits, ALU ops and T-steps.
package cpu_ctrl_pkg;

   typedef enum logic {
      ST_HALT = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

   localparam logic [2:0] SEL_NONE = 3'd0;
   localparam logic [2:0] SEL_AR   = 3'd1;
   localparam logic [2:0] SEL_PC   = 3'd2;
   localparam logic [2:0] SEL_DR   = 3'd3;
   localparam logic [2:0] SEL_AC   = 3'd4;
   localparam logic [2:0] SEL_IR   = 3'd5;
   localparam logic [2:0] SEL_TR   = 3'd6;
   localparam logic [2:0] SEL_MEM  = 3'd7;

   localparam int LD_AR = 5;
   localparam int LD_PC = 4;
   localparam int LD_DR = 3;
   localparam int LD_AC = 2;
   localparam int LD_IR = 1;
   localparam int LD_TR = 0;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_REG = 3'd7;

   localparam int RR_CLA = 11;
   localparam int RR_CMA = 9;
   localparam int RR_INC = 5;
   localparam int RR_SPA = 4;
   localparam int RR_SNA = 3;
   localparam int RR_SZA = 2;
   localparam int RR_HLT = 0;

   localparam logic [2:0] ALU_NOP  = 3'd0;
   localparam logic [2:0] ALU_AND  = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_PASS = 3'd3;
   localparam logic [2:0] ALU_CMA  = 3'd4;

   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;
   localparam int T4 = 4;
   localparam int T5 = 5;
   localparam int T6 = 6;

   typedef struct packed {
      logic cla;
      logic cma;
      logic inc;
      logic spa;
      logic sna;
      logic sza;
      logic hlt;
   } rref_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decode: one-hot opcode, indirect bit and
// the register-reference bits the sequencer acts on.
module cpu_instr_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic [15:0] ir,
   output logic [7:0]  d,
   output logic        ibit,
   output rref_t       rr
);

   logic [ADDR_W-1:0] field;
   logic              unused_bits;

   assign field = ir[ADDR_W-1:0];
   assign ibit  = ir[15];
   assign d     = 8'b0000_0001 << ir[14:12];

   assign rr.cla = field[RR_CLA];
   assign rr.cma = field[RR_CMA];
   assign rr.inc = field[RR_INC];
   assign rr.spa = field[RR_SPA];
   assign rr.sna = field[RR_SNA];
   assign rr.sza = field[RR_SZA];
   assign rr.hlt = field[RR_HLT];

   // Register-reference bits with no function in this CPU.
   assign unused_bits = ^{field[10], field[8:6], field[1]};

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 16-bit accumulator CPU: run/halt FSM plus
// a T0..T6 sequence counter driving bus select, loads and strobes.
module cpu_ctrl_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned SC_W   = 3,
   parameter int unsigned ADDR_W = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [15:0]     ir,
   input  logic            ac_zero,
   input  logic            ac_msb,
   input  logic            dr_zero,
   output logic [2:0]      sel,
   output logic [5:0]      load,
   output logic            inc_pc,
   output logic            inc_ar,
   output logic            inc_dr,
   output logic            inc_ac,
   output logic            clr_ac,
   output logic [2:0]      alu_op,
   output logic            mem_we,
   output logic            halted,
   output logic [SC_W-1:0] sc
);

   run_state_t      state, state_nx;
   logic [SC_W-1:0] sc_nx;
   logic [7:0]      d;
   logic            ibit;
   rref_t           rr;

   cpu_instr_decode #(.ADDR_W(ADDR_W)) u_dec (
      .ir   (ir),
      .d    (d),
      .ibit (ibit),
      .rr   (rr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_HALT;
         sc    <= '0;
      end else begin
         state <= state_nx;
         sc    <= sc_nx;
      end
   end

   assign halted = (state == ST_HALT);

   always_comb begin
      sel      = SEL_NONE;
      load     = '0;
      inc_pc   = 1'b0;
      inc_ar   = 1'b0;
      inc_dr   = 1'b0;
      inc_ac   = 1'b0;
      clr_ac   = 1'b0;
      alu_op   = ALU_NOP;
      mem_we   = 1'b0;
      state_nx = state;
      sc_nx    = '0;
      case (state)
         ST_HALT: begin
            if (start) state_nx = ST_RUN;
         end
         ST_RUN: begin
            sc_nx = sc + SC_W'(1);
            case (int'(sc))
               T0: begin
                  sel         = SEL_PC;
                  load[LD_AR] = 1'b1;
               end
               T1: begin
                  sel         = SEL_MEM;
                  load[LD_IR] = 1'b1;
                  inc_pc      = 1'b1;
               end
               T2: begin
                  sel         = SEL_IR;
                  load[LD_AR] = 1'b1;
               end
               T3: begin
                  if (d[OP_REG]) begin
                     sc_nx = '0;
                     if (!ibit) begin
                        // CLA outranks CMA, CMA outranks INC; skips use pre-update status.
                        clr_ac = rr.cla;
                        if (!rr.cla && rr.cma) begin
                           alu_op      = ALU_CMA;
                           load[LD_AC] = 1'b1;
                        end
                        inc_ac = rr.inc && !rr.cla && !rr.cma;
                        inc_pc = (rr.spa && !ac_msb) || (rr.sna && ac_msb) ||
                                 (rr.sza && ac_zero);
                        if (rr.hlt) state_nx = ST_HALT;
                     end
                  end else if (ibit) begin
                     sel         = SEL_MEM;
                     load[LD_AR] = 1'b1;
                  end
               end
               T4: begin
                  if (d[OP_AND] || d[OP_ADD] || d[OP_LDA] || d[OP_ISZ]) begin
                     sel         = SEL_MEM;
                     load[LD_DR] = 1'b1;
                  end else if (d[OP_STA]) begin
                     sel    = SEL_AC;
                     mem_we = 1'b1;
                     sc_nx  = '0;
                  end else if (d[OP_BUN]) begin
                     sel         = SEL_AR;
                     load[LD_PC] = 1'b1;
                     sc_nx       = '0;
                  end else if (d[OP_BSA]) begin
                     sel    = SEL_PC;
                     mem_we = 1'b1;
                     inc_ar = 1'b1;
                  end else begin
                     sc_nx = '0;
                  end
               end
               T5: begin
                  sc_nx = '0;
                  if (d[OP_AND]) begin
                     alu_op      = ALU_AND;
                     load[LD_AC] = 1'b1;
                  end else if (d[OP_ADD]) begin
                     alu_op      = ALU_ADD;
                     load[LD_AC] = 1'b1;
                  end else if (d[OP_LDA]) begin
                     alu_op      = ALU_PASS;
                     load[LD_AC] = 1'b1;
                  end else if (d[OP_BSA]) begin
                     sel         = SEL_AR;
                     load[LD_PC] = 1'b1;
                  end else if (d[OP_ISZ]) begin
                     inc_dr = 1'b1;
                     sc_nx  = sc + SC_W'(1);
                  end
               end
               T6: begin
                  sc_nx = '0;
                  if (d[OP_ISZ]) begin
                     sel    = SEL_DR;
                     mem_we = 1'b1;
                     inc_pc = dr_zero;
                  end
               end
               default: sc_nx = '0;
            endcase
         end
         default: state_nx = ST_HALT;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: expected control words are queued as each
// step is driven and popped for comparison mid-cycle.
module tb_cpu_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] ir;
   logic        ac_zero, ac_msb, dr_zero;
   logic [2:0]  sel;
   logic [5:0]  load;
   logic        inc_pc, inc_ar, inc_dr, inc_ac, clr_ac;
   logic [2:0]  alu_op;
   logic        mem_we, halted;
   logic [2:0]  sc;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [21:0] exp_q[$];
   string       tag_q[$];

   cpu_ctrl_seq #(.SC_W(3), .ADDR_W(12)) dut (
      .clk(clk), .rst(rst), .start(start), .ir(ir),
      .ac_zero(ac_zero), .ac_msb(ac_msb), .dr_zero(dr_zero),
      .sel(sel), .load(load), .inc_pc(inc_pc), .inc_ar(inc_ar),
      .inc_dr(inc_dr), .inc_ac(inc_ac), .clr_ac(clr_ac), .alu_op(alu_op),
      .mem_we(mem_we), .halted(halted), .sc(sc)
   );

   always #5 clk = ~clk;

   // {sel, load, inc_pc/ar/dr/ac, clr_ac, alu_op, mem_we, halted, sc}
   function automatic logic [21:0] mk(input logic [2:0] s, input logic [5:0] l,
                                      input logic [3:0] inc, input logic clr,
                                      input logic [2:0] alu, input logic we,
                                      input logic h, input logic [2:0] scv);
      return {s, l, inc, clr, alu, we, h, scv};
   endfunction

   function automatic logic [21:0] hlt_word();
      return mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0);
   endfunction

   task automatic expect_out(input string tag, input logic [21:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic chk();
      logic [21:0] obs, e;
      string       t;
      obs = {sel, load, inc_pc, inc_ar, inc_dr, inc_ac, clr_ac, alu_op, mem_we, halted, sc};
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%b required=%b", t, obs, e);
      end
   endtask

   task automatic step(input string tag, input logic [21:0] e);
      expect_out(tag, e);
      #2;
      chk();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] iv, input string nm);
      step({nm, "_t0"}, mk(3'd2, 6'b100000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0));
      step({nm, "_t1"}, mk(3'd7, 6'b000010, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1));
      ir = iv;
      step({nm, "_t2"}, mk(3'd5, 6'b100000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; ir = 16'h0000;
      ac_zero = 1'b0; ac_msb = 1'b0; dr_zero = 1'b0;
      #1;
      expect_out("reset_low", hlt_word());
      chk();
      @(posedge clk); #1;
      rst = 1'b1;
      step("idle_halt", hlt_word());
      start = 1'b1;
      step("start_cycle", hlt_word());
      start = 1'b0;

      // ADD direct
      fetch(16'h1005, "add");
      step("add_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      step("add_t4", mk(3'd7, 6'b001000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
      step("add_t5", mk(3'd0, 6'b000100, 4'b0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd5));

      // LDA indirect
      fetch(16'hA010, "lda");
      step("lda_t3", mk(3'd7, 6'b100000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      step("lda_t4", mk(3'd7, 6'b001000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
      step("lda_t5", mk(3'd0, 6'b000100, 4'b0, 1'b0, 3'd3, 1'b0, 1'b0, 3'd5));

      // ISZ with dr_zero=1 then dr_zero=0
      for (int k = 0; k < 2; k++) begin
         fetch(16'h6020, "isz");
         step("isz_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
         step("isz_t4", mk(3'd7, 6'b001000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
         step("isz_t5", mk(3'd0, 6'b0, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5));
         dr_zero = (k == 0);
         step(k == 0 ? "isz_t6_zero" : "isz_t6_nonzero",
              mk(3'd3, 6'b0, {(k == 0), 3'b000}, 1'b0, 3'd0, 1'b1, 1'b0, 3'd6));
         dr_zero = 1'b0;
      end

      // STA with start held high through the fetch (ignored while running)
      start = 1'b1;
      fetch(16'h3000, "sta");
      start = 1'b0;
      step("sta_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      step("sta_t4", mk(3'd4, 6'b0, 4'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4));

      fetch(16'h4000, "bun");
      step("bun_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      step("bun_t4", mk(3'd1, 6'b010000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4));

      fetch(16'h5000, "bsa");
      step("bsa_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      step("bsa_t4", mk(3'd2, 6'b0, 4'b0100, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4));
      step("bsa_t5", mk(3'd1, 6'b010000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5));

      // Register reference: CLA|CMA|INC|SZA with AC zero
      ac_zero = 1'b1;
      fetch(16'h7A24, "rr_cla");
      step("rr_cla_t3", mk(3'd0, 6'b0, 4'b1000, 1'b1, 3'd0, 1'b0, 1'b0, 3'd3));
      ac_zero = 1'b0;

      // CMA|INC|SZA with AC nonzero: CMA wins over INC, no skip
      fetch(16'h7224, "rr_cma");
      step("rr_cma_t3", mk(3'd0, 6'b000100, 4'b0000, 1'b0, 3'd4, 1'b0, 1'b0, 3'd3));

      // INC|SNA with AC negative
      ac_msb = 1'b1;
      fetch(16'h7028, "rr_inc");
      step("rr_inc_t3", mk(3'd0, 6'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));

      // SPA with AC negative: no skip
      fetch(16'h7010, "rr_spa");
      step("rr_spa_t3", mk(3'd0, 6'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      ac_msb = 1'b0;

      // I/O instruction is a NOP returning to T0
      fetch(16'hF000, "io");
      step("io_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));

      // HLT, then restart
      fetch(16'h7001, "hlt");
      step("hlt_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      step("hlt_after", hlt_word());
      step("hlt_stays", hlt_word());
      start = 1'b1;
      step("restart_cycle", hlt_word());
      start = 1'b0;

      // Asynchronous reset in the middle of ISZ T5
      fetch(16'h6020, "isz_rst");
      step("isz_rst_t3", mk(3'd0, 6'b0, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3));
      step("isz_rst_t4", mk(3'd7, 6'b001000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4));
      #2;
      expect_out("isz_rst_t5_pre", mk(3'd0, 6'b0, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5));
      chk();
      rst = 1'b0;
      #1;
      expect_out("async_reset", hlt_word());
      chk();
      @(posedge clk); #1;
      rst = 1'b1;
      step("post_reset_idle", hlt_word());
      start = 1'b1;
      step("post_reset_start", hlt_word());
      start = 1'b0;
      step("post_reset_t0", mk(3'd2, 6'b100000, 4'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Control sequencer for the 16-bit accumulator CPU; sits directly upstream of the datapath (IR/DR/AC/AR/PC/TR plus SRAM).
Drives the datapath's common-bus select, register load enables, increment/clear strobes, ALU op and memory write.
It replaces hand-driven sel/load stimulus.
Implements fetch, decode, indirect-address, memory-reference and register-reference timing with an internal sequence counter (T0..T6) and a run/halt FSM.

Parameters:
SC_W, 3, sequence counter width (T0..T6)
ADDR_W, 12, address field width in IR[11:0] (documentation/width checks only)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; leaves HALT and begins fetch at T0
ir  input  16  datapath IR; I=ir[15], opcode=ir[14:12], addr/reg-bits=ir[11:0]
ac_zero  input  1  AC == 0
ac_msb  input  1  AC[15]
dr_zero  input  1  DR == 0 (value after any increment registered last cycle)
sel  output  3  bus select: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
load  output  6  register loads: [5]AR [4]PC [3]DR [2]AC [1]IR [0]TR
inc_pc, inc_ar, inc_dr, inc_ac  output  1 each  increment strobes
clr_ac  output  1  clear AC
alu_op  output  3  0 NOP, 1 AND, 2 ADD, 3 PASS_DR, 4 CMA (result into AC when load[2])
mem_we  output  1  write bus value to SRAM[AR]
halted  output  1  FSM in HALT
sc  output  SC_W  current timing step (debug)

Behaviour:
- Reset: FSM=HALT, sc=0, halted=1. All other outputs are 0 and remain 0 while halted.
- All control outputs are combinational from (state, sc, ir, status inputs). State and sc are registered.
- HALT: start=1 -> RUN, sc=0 next cycle. start while RUN is ignored.
- Every RUN step: sc increments unless the step says "sc<-0".
- T0: sel=PC, load AR.
- T1: sel=MEM, load IR, inc_pc.
- T2: sel=IR, load AR. The datapath keeps IR[11:0].
- T3, opcode!=7:
  - I=1: sel=MEM, load AR.
  - I=0: no-op.
- T3, opcode=7, I=0 (register-ref), sc<-0. Bits act in the same cycle:
  - b11 CLA -> clr_ac.
  - b9 CMA -> alu_op=CMA, load AC.
  - b5 INC -> inc_ac.
  - Priority: CLA suppresses CMA/INC; CMA suppresses INC.
  - Skips are evaluated on pre-update status and OR'd into inc_pc: b4 SPA (!ac_msb), b3 SNA (ac_msb), b2 SZA (ac_zero).
  - b0 HLT -> RUN->HALT at end of cycle. Other bits execute in that same cycle.
- T3, opcode=7, I=1: I/O, unimplemented. NOP, sc<-0.
- Memory-reference, T4 onward:
  - AND: T4 sel=MEM, load DR. T5 alu_op=AND, load AC, sc<-0.
  - ADD: T4 same as AND. T5 alu_op=ADD, load AC, sc<-0.
  - LDA: T4 same as AND. T5 alu_op=PASS_DR, load AC, sc<-0.
  - STA: T4 sel=AC, mem_we, sc<-0.
  - BUN: T4 sel=AR, load PC, sc<-0.
  - BSA: T4 sel=PC, mem_we, inc_ar. T5 sel=AR, load PC, sc<-0.
  - ISZ: T4 sel=MEM, load DR. T5 inc_dr. T6 sel=DR, mem_we, inc_pc if dr_zero, sc<-0.
- sc never exceeds 6. An unreachable sc value forces sc<-0 with outputs 0.
- Async reset at any step aborts immediately: outputs 0 in the same cycle, and the partial instruction is discarded.
- At most one bit of load plus the sel source is active per cycle, except T3 register-ref, which has multiple strobes by design.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - sel encodings (SEL_AR..SEL_MEM)
  - load bit indices (LD_AR..LD_TR)
  - opcode constants (OP_AND..OP_REG)
  - register-ref bit positions
  - ALU op codes
  - T-step constants
- One sub-module, cpu_instr_decode: combinational; ir -> one-hot D0..D7, I, reg-ref bit vector.

Test Plan:
- Reset low then high -> halted=1, sel=0, load=0. start pulse -> T0 sel=2 load=100000; T1 sel=7 load=000010 inc_pc=1; T2 sel=5 load=100000.
- ir=0x1005 (ADD direct) -> T3 all 0; T4 sel=7 load=001000; T5 alu_op=2 load=000100; next cycle sc=0.
- ir=0xA010 (LDA indirect) -> T3 sel=7 load=100000; T5 alu_op=3 load=000100.
- ir=0x6020 (ISZ), dr_zero=1 at T6 -> T5 inc_dr=1; T6 sel=3 mem_we=1 inc_pc=1. Repeat with dr_zero=0 -> inc_pc=0.
- ir=0x7A24 (CLA|CMA|INC|SZA), ac_zero=1 -> T3 clr_ac=1, alu_op=0, inc_ac=0, inc_pc=1, sc->0.
- ir=0x7001 (HLT) -> halted=1 after T3, outputs 0. start resumes at T0. Reset asserted at ISZ T5 -> outputs 0 immediately, halted=1.
